uart_tx_arbiter: RTL

//   Shares one UART serial TX line among NUM_REQ byte requesters.

---
 rtl/uart_tx_arbiter_if.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Purpose: request/serial bundle between NUM_REQ byte requesters and the
//          shared UART TX arbiter.
// Signals:
//   clk_en     baud tick, one-cycle pulse per bit period
//   req_valid  per-requester word pending
//   req_data   requester i owns bits [i*DATA_BITS +: DATA_BITS]
//   req_ready  one-hot accept strobe (combinational in the arbiter)
//   tx         serial line, idle high
//   busy       high while a frame is on the line
//   grant_id   index of the requester owning the current frame
// Modports: master = requester/baud side, slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_BITS = 8
) ();
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                           clk_en;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*DATA_BITS-1:0]   req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           tx;
  logic                           busy;
  logic [IDW-1:0]                 grant_id;

  modport master (
    output clk_en, req_valid, req_data,
    input  req_ready, tx, busy, grant_id
  );

  modport slave (
    input  clk_en, req_valid, req_data,
    output req_ready, tx, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one UART TX line among NUM_REQ byte requesters with
//          round-robin arbitration; frames the winner's word as start bit,
//          DATA_BITS data bits LSB-first and STOP_BITS stop bits, one bit per
//          clk_en tick.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  synchronous active-low reset (0 = reset)
//   bus  uart_tx_arbiter_if.slave: clk_en, req_valid, req_data in;
//        req_ready (combinational), tx, busy, grant_id out (registered)
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW  = $clog2(DATA_BITS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]           r_state,    w_state_nxt;
  logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
  logic [CW-1:0]        r_bit_cnt,  w_bit_cnt_nxt;
  logic                 r_stop_cnt, w_stop_cnt_nxt;
  logic [IDW-1:0]       r_rr_ptr,   w_rr_ptr_nxt;
  logic [IDW-1:0]       r_grant_id, w_grant_id_nxt;
  logic                 r_tx,       w_tx_nxt;
  logic                 r_busy,     w_busy_nxt;

  logic                 w_found;
  logic [IDW-1:0]       w_winner;
  logic [DATA_BITS-1:0] w_word;
  logic                 w_last_stop;
  logic                 w_grant;
  logic [NUM_REQ-1:0]   w_ready;

  // Round-robin search starting just after the last winner, plus its data word
  always_comb begin : rr_search
    logic [IDW-1:0] idx;
    idx      = '0;
    w_found  = 1'b0;
    w_winner = '0;
    w_word   = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      idx = IDW'((int'(r_rr_ptr) + k) % int'(NUM_REQ));
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!w_found && (idx == IDW'(i)) && bus.req_valid[i]) begin
          w_found  = 1'b1;
          w_winner = idx;
        end
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_winner == IDW'(i)) w_word = bus.req_data[i*int'(DATA_BITS) +: DATA_BITS];
    end
  end

  // Next-state, framing and accept strobe
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_grant_id_nxt = r_grant_id;
    w_tx_nxt       = r_tx;
    w_busy_nxt     = r_busy;
    w_ready        = '0;

    w_last_stop = (r_state == S_STOP) && (r_stop_cnt == 1'(STOP_BITS - 1));
    // A new frame may start from IDLE or seamlessly after the final stop tick
    w_grant     = rst && bus.clk_en && w_found && ((r_state == S_IDLE) || w_last_stop);

    if (w_grant) begin
      w_ready        = NUM_REQ'(1) << w_winner;
      w_shift_nxt    = w_word;
      w_rr_ptr_nxt   = w_winner;
      w_grant_id_nxt = w_winner;
      w_busy_nxt     = 1'b1;
      w_tx_nxt       = 1'b0;
      w_stop_cnt_nxt = 1'b0;
      w_state_nxt    = S_START;
    end else if (rst && bus.clk_en) begin
      case (r_state)
        S_START: begin
          w_state_nxt   = S_DATA;
          w_tx_nxt      = r_shift[0];
          w_bit_cnt_nxt = '0;
        end
        S_DATA: begin
          if (r_bit_cnt == CW'(DATA_BITS - 1)) begin
            w_state_nxt    = S_STOP;
            w_tx_nxt       = 1'b1;
            w_stop_cnt_nxt = 1'b0;
          end else begin
            // r_shift[1] becomes bit 0 after this shift
            w_shift_nxt   = r_shift >> 1;
            w_tx_nxt      = r_shift[1];
            w_bit_cnt_nxt = r_bit_cnt + CW'(1);
          end
        end
        S_STOP: begin
          w_tx_nxt = 1'b1;
          if (!w_last_stop) begin
            w_stop_cnt_nxt = r_stop_cnt + 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // State register; reset re-arms requester 0 as top priority
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_rr_ptr   <= IDW'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.tx        = r_tx;
  assign bus.busy      = r_busy;
  assign bus.grant_id  = r_grant_id;

endmodule
